// File: rtl/bcd_e3_serial_conv_pkg.sv
`default_nettype none
// ============================================================================
// Package   : bcd_e3_pkg
// Purpose   : Shared constants, the bit-index state type and the digit
//             validity helper for the BCD / Excess-3 serial converter.
// Revision  : 1.0 - initial release
// ============================================================================
package bcd_e3_pkg;

  localparam logic       DIR_BCD2E3 = 1'b0;
  localparam logic       DIR_E32BCD = 1'b1;

  localparam logic [3:0] E3_OFFSET  = 4'b0011;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] E3_MIN     = 4'd3;
  localparam logic [3:0] E3_MAX     = 4'd12;

  // Position of the current bit inside its digit, LSB first.
  typedef enum logic [1:0] {
    BIT0 = 2'd0,
    BIT1 = 2'd1,
    BIT2 = 2'd2,
    BIT3 = 2'd3
  } bit_idx_t;

  // True when the complete input digit is outside the legal code range.
  function automatic logic digit_invalid(input logic dir_v, input logic [3:0] digit);
    if (dir_v == DIR_BCD2E3) begin
      return digit > BCD_MAX;
    end
    return (digit < E3_MIN) || (digit > E3_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_e3_serial_conv_if.sv
`default_nettype none
// ============================================================================
// Interface : bcd_e3_serial_conv_if
// Purpose   : Serial stream bundle between the digit source (master) and the
//             converter (slave): input bit/framing plus converted outputs.
// Revision  : 1.0 - initial release
// ============================================================================
interface bcd_e3_serial_conv_if;
  logic d_in;
  logic in_valid;
  logic in_sof;
  logic dir;
  logic d_out;
  logic out_valid;
  logic out_sof;
  logic out_eof;
  logic err_digit;
  logic err_word;

  modport master (
    output d_in, in_valid, in_sof, dir,
    input  d_out, out_valid, out_sof, out_eof, err_digit, err_word
  );

  modport slave (
    input  d_in, in_valid, in_sof, dir,
    output d_out, out_valid, out_sof, out_eof, err_digit, err_word
  );
endinterface
`default_nettype wire

// File: rtl/bcd_e3_serial_conv_digit_fsm.sv
`default_nettype none
// ============================================================================
// Module    : bcd_e3_digit_fsm
// Purpose   : Per-digit Mealy core. Adds or subtracts 3 one bit at a time,
//             tracks the bit position and the carry/borrow, and (with
//             BCD_E3_ERR_CHK_EN) keeps a bit history to flag invalid digits.
// Revision  : 1.0 - initial release
// ============================================================================
module bcd_e3_digit_fsm
  import bcd_e3_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic accept,     // bit is part of a word this cycle
  input  wire logic restart,    // accepted start-of-frame: treat as bit 0
  input  wire logic d_in,
  input  wire logic dir_eff,
  output logic      d_out,
  output logic      last_bit    // accepted bit is bit 3 of its digit
`ifdef BCD_E3_ERR_CHK_EN
  ,
  output logic      digit_bad   // digit completing this cycle is invalid
`endif
);

  bit_idx_t bit_idx;
  bit_idx_t k;
  logic     cb;
  logic     cb_eff;
  logic     kbit;
  logic     cb_next;

  // Bit position, constant bit and the carry/borrow of the current bit.
  always_comb begin
    k       = restart ? BIT0 : bit_idx;
    cb_eff  = (k == BIT0) ? 1'b0 : cb;
    kbit    = E3_OFFSET[k];
    if (dir_eff == DIR_BCD2E3) begin
      cb_next = (d_in & kbit) | (d_in & cb_eff) | (kbit & cb_eff);
    end else begin
      cb_next = (~d_in & (kbit | cb_eff)) | (kbit & cb_eff);
    end
    d_out    = accept ? (d_in ^ kbit ^ cb_eff) : 1'b0;
    last_bit = accept && (k == BIT3);
  end

  // Advance the bit position and carry/borrow on every accepted bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx <= BIT0;
      cb      <= 1'b0;
    end else if (accept) begin
      bit_idx <= bit_idx_t'(k + 2'd1);
      cb      <= cb_next;
    end
  end

`ifdef BCD_E3_ERR_CHK_EN
  logic [2:0] hist;

  // Capture bits 0..2 of the digit so bit 3 can judge the whole code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 3'b000;
    end else if (accept) begin
      case (k)
        BIT0:    hist[0] <= d_in;
        BIT1:    hist[1] <= d_in;
        BIT2:    hist[2] <= d_in;
        default: hist    <= hist;
      endcase
    end
  end

  assign digit_bad = last_bit && digit_invalid(dir_eff, {d_in, hist});
`endif

endmodule
`default_nettype wire

// File: rtl/bcd_e3_serial_conv.sv
`default_nettype none
// ============================================================================
// Module    : bcd_e3_serial_conv
// Purpose   : Bit-serial BCD <-> Excess-3 converter with word framing,
//             runtime direction select and optional invalid-digit flags.
//             Optional feature macro: BCD_E3_ERR_CHK_EN (err_digit/err_word).
// Revision  : 1.0 - initial release
// ============================================================================
module bcd_e3_serial_conv
  import bcd_e3_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  bcd_e3_serial_conv_if.slave   bus
);

  localparam int              CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]   LAST_DIGIT = CW'(NUM_DIGITS - 1);

  logic          in_word;
  logic          dir_q;
  logic [CW-1:0] digit_cnt;

  logic          sof_acc;
  logic          accept;
  logic          dir_eff;
  logic [CW-1:0] digit_eff;
  logic          last_digit;
  logic          last_bit;

  assign sof_acc    = bus.in_valid & bus.in_sof;
  assign accept     = bus.in_valid & (bus.in_sof | in_word);
  assign dir_eff    = bus.in_sof ? bus.dir : dir_q;
  assign digit_eff  = bus.in_sof ? '0 : digit_cnt;
  assign last_digit = (digit_eff == LAST_DIGIT);

  assign bus.out_valid = bus.in_valid;
  assign bus.out_sof   = sof_acc;
  assign bus.out_eof   = last_bit & last_digit;

`ifdef BCD_E3_ERR_CHK_EN
  logic digit_bad;
`endif

  bcd_e3_digit_fsm u_digit (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .restart   (sof_acc),
    .d_in      (bus.d_in),
    .dir_eff   (dir_eff),
    .d_out     (bus.d_out),
    .last_bit  (last_bit)
`ifdef BCD_E3_ERR_CHK_EN
    ,
    .digit_bad (digit_bad)
`endif
  );

  // Word framing: direction latch, digit counter and in-word flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_word   <= 1'b0;
      dir_q     <= DIR_BCD2E3;
      digit_cnt <= '0;
    end else if (accept) begin
      if (bus.in_sof) begin
        dir_q <= bus.dir;
      end
      if (last_bit) begin
        digit_cnt <= last_digit ? '0 : CW'(digit_eff + 1'b1);
        in_word   <= ~last_digit;
      end else begin
        digit_cnt <= digit_eff;
        in_word   <= 1'b1;
      end
    end
  end

`ifdef BCD_E3_ERR_CHK_EN
  logic err_digit_q;
  logic err_word_q;

  // Error flags: one-cycle digit pulse, word flag sticky until the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_digit_q <= 1'b0;
      err_word_q  <= 1'b0;
    end else begin
      err_digit_q <= accept & digit_bad;
      if (sof_acc) begin
        err_word_q <= 1'b0;
      end else if (accept & digit_bad) begin
        err_word_q <= 1'b1;
      end
    end
  end

  assign bus.err_digit = err_digit_q;
  assign bus.err_word  = err_word_q;
`else
  assign bus.err_digit = 1'b0;
  assign bus.err_word  = 1'b0;
`endif

endmodule
`default_nettype wire
